// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
// Memory-mapped UART transmitter sitting on the processor data bus.
// Stores to TXDATA are queued in a small circular FIFO and serialized 8N1
// (or 8E1 when UART_TX_PARITY_EN is defined) on tx_out, LSB first.
//
// Register window (word offsets from BASE_ADDRESS):
//   +0 TXDATA  write: enqueue io_memory_write[7:0]
//   +4 STATUS  read : {bit9 parity_en, bits[8:4] count, bit3 overflow,
//                      bit2 tx_busy, bit1 empty, bit0 full}
//   +8 CTRL    write: bit0=1 flushes the FIFO and clears overflow
//
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit).
//
// Ports:
//   clk, rst          processor clock, asynchronous active-high reset
//   address           processor data address
//   MemWrite/MemRead  store / load strobes
//   io_memory_write   store data
//   io_memory_read    registered STATUS load data (0 when not valid)
//   valid_io_read     io_memory_read is valid this cycle
//   tx_out            serial line, idles high
//   tx_busy           a frame is in progress
module uart_tx_mmio #(
  parameter int unsigned INPUT_CLOCK_RATE = 33_333_333,
  parameter int unsigned BAUD_RATE        = 19_200,
  parameter int unsigned FIFO_DEPTH       = 8,
  parameter logic [31:0] BASE_ADDRESS     = 32'h00007f40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] io_memory_write,
  output logic [31:0] io_memory_read,
  output logic        valid_io_read,
  output logic        tx_out,
  output logic        tx_busy
);

  localparam int unsigned DIV      = INPUT_CLOCK_RATE / BAUD_RATE;
  localparam int unsigned CNT_W    = $clog2(DIV + 1);
  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [4:0]       DEPTH_CNT = 5'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_BIT = 1'b1;
`else
  localparam logic PAR_BIT = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   baud_cnt_q, baud_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]         count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               rd_valid_q, rd_valid_d;
  logic [31:0]        rd_data_q, rd_data_d;

  logic sel_data, sel_status, sel_ctrl;
  logic push_req, push, pop, flush, status_rd;
  logic fifo_full, fifo_empty, bit_done;
  logic [7:0]  head;
  logic [31:0] status_word;
  logic        unused_wdata;

  assign unused_wdata = ^io_memory_write[31:8];

  // Bus decode; only exact word addresses inside the window respond.
  assign sel_data   = (address == BASE_ADDRESS);
  assign sel_status = (address == BASE_ADDRESS + 32'd4);
  assign sel_ctrl   = (address == BASE_ADDRESS + 32'd8);

  // Full is judged on the registered count, so a store while full is dropped
  // even if the transmitter pops in the same cycle. Pop also uses the
  // registered count, so a byte pushed into an empty FIFO leaves next cycle.
  assign fifo_full  = (count_q == DEPTH_CNT);
  assign fifo_empty = (count_q == 5'd0);
  assign push_req   = MemWrite & sel_data;
  assign push       = push_req & ~fifo_full;
  assign pop        = (state_q == IDLE) & ~fifo_empty;
  assign flush      = MemWrite & sel_ctrl & io_memory_write[0];
  assign status_rd  = MemRead & sel_status;
  assign head       = mem_q[rd_ptr_q];
  assign bit_done   = (baud_cnt_q == DIV_LAST);

  assign status_word = {22'd0, PAR_BIT, count_q, overflow_q, tx_busy,
                        fifo_empty, fifo_full};

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state plus baud/bit counters and shift register; the baud
  // counter restarts at zero on every state entry.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      IDLE: begin
        baud_cnt_d = '0;
        if (pop) begin
          shift_d   = head;
          bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^head;
`endif
          state_d   = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        baud_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // FSM outputs, decoded from the state register so reset forces the line
  // high immediately.
  always_comb begin
    tx_out  = 1'b1;
    tx_busy = 1'b1;
    case (state_q)
      IDLE:   tx_busy = 1'b0;
      START:  tx_out  = 1'b0;
      DATA:   tx_out  = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_out  = parity_q;
`endif
      default: tx_out = 1'b1;
    endcase
  end

  // FIFO pointers, count and sticky overflow. Flush wins over a same-cycle
  // pop (the popped byte is still sent) and leaves the FIFO empty.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (push) begin
      mem_d[wr_ptr_q] = io_memory_write[7:0];
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + {4'd0, push} - {4'd0, pop};
    if (push_req && fifo_full) overflow_d = 1'b1;
    if (status_rd) overflow_d = 1'b0;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = 5'd0;
      overflow_d = 1'b0;
    end
  end

  // STATUS loads are registered; the value is the one seen in the request cycle.
  always_comb begin
    rd_valid_d = status_rd;
    rd_data_d  = status_rd ? status_word : 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= 5'd0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'd0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // FIFO storage carries no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign valid_io_read  = rd_valid_q;
  assign io_memory_read = rd_data_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio with DIV = 1000/100 = 10.
// A frame-level model (byte queue + frame bit vector indexed by elapsed
// cycles) predicts tx_out, tx_busy and STATUS loads every cycle; directed
// tests add hand-computed literal checks and a small line receiver.
module tb_uart_tx_mmio;

   localparam int          DIV   = 10;
   localparam int          DEPTH = 8;
   localparam logic [31:0] BASE  = 32'h00007f40;
`ifdef UART_TX_PARITY_EN
   localparam int          FRAME_BITS = 11;
   localparam logic [31:0] PAR_FLAG   = 32'h200;
`else
   localparam int          FRAME_BITS = 10;
   localparam logic [31:0] PAR_FLAG   = 32'h0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] address = 32'd0;
   logic        memWrite = 1'b0;
   logic        memRead = 1'b0;
   logic [31:0] writeData = 32'd0;
   logic [31:0] readData;
   logic        readValid;
   logic        txOut;
   logic        txBusy;

   int assertCount = 0;
   int failCount = 0;

   uart_tx_mmio #(
      .INPUT_CLOCK_RATE(1000),
      .BAUD_RATE(100),
      .FIFO_DEPTH(DEPTH),
      .BASE_ADDRESS(BASE)
   ) dut (
      .clk(clock),
      .rst(reset),
      .address(address),
      .MemWrite(memWrite),
      .MemRead(memRead),
      .io_memory_write(writeData),
      .io_memory_read(readData),
      .valid_io_read(readValid),
      .tx_out(txOut),
      .tx_busy(txBusy)
   );

   // Free-running 10-unit clock
   always #5 clock = ~clock;

   // One comparison: counts it and reports a failure line on mismatch
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Model state: byte queue, sticky overflow, position inside the current frame
   logic [7:0]  mQ[$];
   logic        mOvf = 1'b0;
   int          mFc = -1;
   logic [10:0] mFrame = '1;
   logic        mRdValid = 1'b0;
   logic [31:0] mRdData = 32'd0;
   int          sizePre;
   logic        busyPre, fullPre, emptyPre;
   logic [7:0]  popByte;

   // Model update: every decision uses the state before this edge
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mQ.delete();
         mOvf = 1'b0;
         mFc = -1;
         mRdValid = 1'b0;
         mRdData = 32'd0;
      end else begin
         sizePre  = mQ.size();
         busyPre  = (mFc >= 0);
         fullPre  = (sizePre == DEPTH);
         emptyPre = (sizePre == 0);
         mRdValid = 1'b0;
         mRdData  = 32'd0;
         if (memRead && address == BASE + 32'd4) begin
            mRdValid = 1'b1;
            mRdData  = PAR_FLAG | (32'(sizePre) << 4) | {28'd0, mOvf, busyPre, emptyPre, fullPre};
            mOvf     = 1'b0;
         end
         if (mFc >= 0) begin
            mFc++;
            if (mFc == FRAME_BITS * DIV) mFc = -1;
         end else if (!emptyPre) begin
            popByte = mQ.pop_front();
`ifdef UART_TX_PARITY_EN
            mFrame = {1'b1, ^popByte, popByte, 1'b0};
`else
            mFrame = {2'b11, popByte, 1'b0};
`endif
            mFc = 0;
         end
         if (memWrite && address == BASE + 32'd8 && writeData[0]) begin
            mQ.delete();
            mOvf = 1'b0;
         end
         if (memWrite && address == BASE) begin
            if (fullPre) mOvf = 1'b1;
            else mQ.push_back(writeData[7:0]);
         end
      end
   end

   // Line receiver and busy-length tracker, fed from the DUT pins
   logic [7:0] rxQ[$];
   int         rxIdx = -1;
   logic       prevTx = 1'b1;
   logic [7:0] rxShift = 8'd0;
   logic       rxPar = 1'b0;
   int         busyRun = 0;
   int         lastBusyLen = 0;
   logic       expTx;

   // Per-cycle compare against the model, then receiver bookkeeping
   always @(posedge clock) begin
      #1;
      expTx = (mFc < 0) ? 1'b1 : mFrame[mFc / DIV];
      checkOutput("tx_out", {31'd0, txOut}, {31'd0, expTx});
      checkOutput("tx_busy", {31'd0, txBusy}, {31'd0, (mFc >= 0)});
      checkOutput("valid_io_read", {31'd0, readValid}, {31'd0, mRdValid});
      checkOutput("io_memory_read", readData, mRdData);
      if (reset) begin
         rxIdx = -1;
      end else if (rxIdx < 0) begin
         if (prevTx && !txOut) rxIdx = 0;
      end else begin
         rxIdx++;
         if (rxIdx % DIV == DIV / 2) begin
            if (rxIdx / DIV >= 1 && rxIdx / DIV <= 8) rxShift[rxIdx / DIV - 1] = txOut;
            if (rxIdx / DIV == 9) rxPar = txOut;
            if (rxIdx / DIV == FRAME_BITS - 1) begin
               rxQ.push_back(rxShift);
               rxIdx = -1;
            end
         end
      end
      prevTx = txOut;
      if (txBusy) busyRun++;
      else if (busyRun > 0) begin
         lastBusyLen = busyRun;
         busyRun = 0;
      end
   end

   // One bus cycle starting at a falling edge; strobes drop at the next one
   task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr, input logic [31:0] data);
      address   = addr;
      memWrite  = wr;
      memRead   = rd;
      writeData = data;
      @(negedge clock);
      memWrite  = 1'b0;
      memRead   = 1'b0;
      address   = 32'd0;
      writeData = 32'd0;
   endtask

   // Wait until everything queued has been sent, bounded by a cycle budget
   task automatic waitQuiet(input int budget);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge clock);
         if (!txBusy && mQ.size() == 0 && rxIdx < 0) break;
      end
      if (i == budget) checkOutput("waitQuiet timeout", 32'd0, 32'd1);
   endtask

   // Pop one received byte, or an impossible value when nothing arrived
   task automatic checkRx(input string name, input logic [7:0] expected);
      logic [31:0] got;
      got = 32'hdead;
      if (rxQ.size() > 0) got = {24'd0, rxQ.pop_front()};
      checkOutput(name, got, {24'd0, expected});
   endtask

   // Directed sequence
   initial begin
      logic [8:0] lit55;
      lit55 = 9'b010101010;

      repeat (3) @(negedge clock);
      checkOutput("reset tx_out", {31'd0, txOut}, 32'd1);
      checkOutput("reset tx_busy", {31'd0, txBusy}, 32'd0);
      checkOutput("reset valid", {31'd0, readValid}, 32'd0);
      checkOutput("reset rdata", readData, 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Single 0x55 frame, start + data sampled mid-bit
      $display("[TB] single frame 0x55");
      applyStimulus(1'b1, 1'b0, BASE, 32'h55);
      repeat (6) @(negedge clock);
      for (int b = 0; b < 9; b++) begin
         checkOutput($sformatf("0x55 bit %0d", b), {31'd0, txOut}, {31'd0, lit55[b]});
         checkOutput($sformatf("0x55 busy %0d", b), {31'd0, txBusy}, 32'd1);
         repeat (10) @(negedge clock);
      end
      repeat (20) @(negedge clock);
      checkOutput("0x55 idle busy", {31'd0, txBusy}, 32'd0);
`ifdef UART_TX_PARITY_EN
      checkOutput("0x55 frame length", lastBusyLen, 32'd110);
`else
      checkOutput("0x55 frame length", lastBusyLen, 32'd100);
`endif
      checkRx("0x55 rx", 8'h55);

      // Three back-to-back stores
      $display("[TB] three frames");
      rxQ.delete();
      applyStimulus(1'b1, 1'b0, BASE, 32'h41);
      applyStimulus(1'b1, 1'b0, BASE, 32'h42);
      applyStimulus(1'b1, 1'b0, BASE, 32'h43);
      waitQuiet(600);
      checkRx("rx 0x41", 8'h41);
      checkRx("rx 0x42", 8'h42);
      checkRx("rx 0x43", 8'h43);
      applyStimulus(1'b0, 1'b1, BASE + 32'd4, 32'd0);
      checkOutput("status after three", readData, 32'h2 | PAR_FLAG);
      checkOutput("status valid", {31'd0, readValid}, 32'd1);
      @(negedge clock);
      checkOutput("valid one cycle", {31'd0, readValid}, 32'd0);

      // Overflow: one frame on the line, then nine stores into an 8-deep FIFO
      $display("[TB] overflow");
      rxQ.delete();
      applyStimulus(1'b1, 1'b0, BASE, 32'hA5);
      repeat (5) @(negedge clock);
      for (int k = 0; k < 9; k++) applyStimulus(1'b1, 1'b0, BASE, 32'h10 + 32'(k));
      applyStimulus(1'b0, 1'b1, BASE + 32'd4, 32'd0);
      checkOutput("status overflow", readData, 32'h8D | PAR_FLAG);
      applyStimulus(1'b0, 1'b1, BASE + 32'd4, 32'd0);
      checkOutput("status overflow cleared", readData, 32'h85 | PAR_FLAG);
      waitQuiet(2000);
      checkOutput("overflow frame count", rxQ.size(), 32'd9);
      checkRx("rx 0xA5", 8'hA5);
      for (int k = 0; k < 8; k++) checkRx($sformatf("rx queued %0d", k), 8'h10 + 8'(k));

      // Idle STATUS read and an out-of-window load
      $display("[TB] idle loads");
      applyStimulus(1'b0, 1'b1, BASE + 32'd4, 32'd0);
      checkOutput("idle status", readData, 32'h2 | PAR_FLAG);
      applyStimulus(1'b0, 1'b1, BASE + 32'h10, 32'd0);
      checkOutput("outside valid", {31'd0, readValid}, 32'd0);
      checkOutput("outside rdata", readData, 32'd0);

      // Flush while busy: current frame completes, queued bytes vanish
      $display("[TB] flush");
      rxQ.delete();
      applyStimulus(1'b1, 1'b0, BASE, 32'h3C);
      repeat (3) @(negedge clock);
      applyStimulus(1'b1, 1'b0, BASE, 32'h01);
      applyStimulus(1'b1, 1'b0, BASE, 32'h02);
      applyStimulus(1'b1, 1'b0, BASE, 32'h03);
      applyStimulus(1'b1, 1'b0, BASE + 32'd8, 32'h1);
      applyStimulus(1'b0, 1'b1, BASE + 32'd4, 32'd0);
      checkOutput("status after flush", readData, 32'h6 | PAR_FLAG);
      waitQuiet(600);
      checkOutput("flush frame count", rxQ.size(), 32'd1);
      checkRx("rx 0x3C", 8'h3C);

      // Reset in the middle of the data bits
      $display("[TB] reset mid-frame");
      rxQ.delete();
      applyStimulus(1'b1, 1'b0, BASE, 32'h0F);
      repeat (30) @(negedge clock);
      checkOutput("mid-frame busy", {31'd0, txBusy}, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("async reset tx_out", {31'd0, txOut}, 32'd1);
      checkOutput("async reset busy", {31'd0, txBusy}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      applyStimulus(1'b0, 1'b1, BASE + 32'd4, 32'd0);
      checkOutput("status after reset", readData, 32'h2 | PAR_FLAG);
      repeat (5) @(negedge clock);
      checkOutput("line stays idle", {31'd0, txOut}, 32'd1);

      // Frame length and parity of 0x07
      $display("[TB] frame 0x07");
      rxQ.delete();
      applyStimulus(1'b1, 1'b0, BASE, 32'h07);
      waitQuiet(300);
      @(negedge clock);
`ifdef UART_TX_PARITY_EN
      checkOutput("0x07 frame length", lastBusyLen, 32'd110);
      checkOutput("0x07 parity bit", {31'd0, rxPar}, 32'd1);
`else
      checkOutput("0x07 frame length", lastBusyLen, 32'd100);
`endif
      checkRx("rx 0x07", 8'h07);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Watchdog so the run always terminates
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the processor data bus, downstream of the multicycle processor.
- Processor stores bytes to a data register; the block queues them in a small FIFO and serializes them 8N1 on a TX pin.
- Exposes a status register so software can poll full/empty/busy/overflow.
- Read data joins the system read-data mux via a valid flag, in the same way as other I/O peripherals.

Parameters:
- INPUT_CLOCK_RATE, 33_333_333, clk frequency in Hz (processor clock = 100 MHz / 3)
- BAUD_RATE, 19_200, serial bit rate
- FIFO_DEPTH, 8, byte entries; power of two, 2..16
- BASE_ADDRESS, 32'h00007f40, word-aligned base of the 3-word register window

Ports:
- clk  input  1  processor clock
- rst  input  1  reset; asynchronous, active-high
- address  input  32  processor data address
- MemWrite  input  1  store strobe, one cycle per store
- MemRead  input  1  load strobe
- io_memory_write  input  32  store data
- io_memory_read  output  32  load data
- valid_io_read  output  1  io_memory_read is valid this cycle
- tx_out  output  1  serial line, idles high
- tx_busy  output  1  a frame is in progress

Behaviour:
- Register map (word offsets from BASE_ADDRESS):
  - +0 TXDATA: write only; a store enqueues io_memory_write[7:0].
  - +4 STATUS: read only. Bit0 full, bit1 empty, bit2 tx_busy, bit3 overflow (sticky), bits[8:4] count, other bits 0.
  - +8 CTRL: write bit0=1 to flush the FIFO and clear overflow. The current frame is not aborted.
- Addresses outside the window are ignored. Stores to STATUS and loads from TXDATA/CTRL do nothing.
- Loads:
  - A load with MemRead=1 at BASE+4 is registered. The cycle after, valid_io_read=1 for exactly one cycle and io_memory_read holds STATUS as sampled in the request cycle.
  - A STATUS read clears overflow in the cycle it is sampled.
  - At all other times valid_io_read=0 and io_memory_read=0.
- Baud timing:
  - DIV = INPUT_CLOCK_RATE / BAUD_RATE, integer truncation. Each bit lasts exactly DIV clk cycles.
  - The baud counter restarts at 0 on entry to every state.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: tx_out=1. If the FIFO is not empty, pop the head byte into a shift register and go to START on the next cycle.
  - START: tx_out=0 for DIV cycles, then DATA.
  - DATA: tx_out = shift[0], LSB first. Shift every DIV cycles. After 8 bits go to STOP; the bit counter runs 0..7.
  - STOP: tx_out=1 for DIV cycles, then IDLE. A queued byte starts in START 1 cycle after STOP ends, so the inter-frame gap is 1 clk.
  - tx_busy=1 in START, DATA and STOP.
- FIFO:
  - Circular buffer with wrap-around read/write pointers and a count of 0..FIFO_DEPTH.
  - Full is evaluated before any same-cycle pop. A store while full is dropped and sets overflow, even if a pop occurs that cycle.
  - A push to an empty FIFO in IDLE is popped on the following cycle, not the same cycle.
  - Flush in the same cycle as a TXDATA store is not possible, since the addresses differ. Flush in the same cycle as a pop leaves count at 0.
- Reset values (asynchronous, immediate): state IDLE, tx_out=1, tx_busy=0, FIFO empty, pointers 0, overflow 0, valid_io_read=0, io_memory_read=0.
- Reset mid-frame truncates the frame; the line returns high at once.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for DIV cycles, so a frame is 11 bits. STATUS bit9 reads 1.
- Undefined: 8N1, 10-bit frames, STATUS bit9 reads 0.

Test Plan (INPUT_CLOCK_RATE=1000, BAUD_RATE=100, so DIV=10):
- Reset, then store 0x55 to BASE+0 → tx_out low for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, then high for 10 cycles. tx_busy high for 100 cycles, then 0.
- Store 0x41, 0x42, 0x43 back-to-back → three frames with a 1-cycle idle gap between them. The bytes decode in order 0x41, 0x42, 0x43, and STATUS ends with empty=1, count=0.
- With the line busy, store 9 more bytes (FIFO_DEPTH=8) → STATUS reads full=1, count=8, overflow=1. A second STATUS read shows overflow=0. Exactly 8 further frames are sent.
- Load BASE+4 while idle and empty → valid_io_read=1 one cycle later with io_memory_read=32'h00000002. A load at BASE+0x10 → valid_io_read stays 0.
- Assert rst during the DATA state of frame 0x0F → tx_out=1 and tx_busy=0 immediately. After release, STATUS reads 0x2.
- With UART_TX_PARITY_EN, store 0x07 → the parity bit is 1 and the frame lasts 110 cycles. Without the macro → frame lasts 100 cycles.
